// File: rtl/robs_divider.sv
// Signed iterative restoring divider (truncating), companion to the Robertson's multiplier.
// One quotient bit per cycle; start/busy/done handshake with registered results and flags.
module robs_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_d;
    // Partial remainder never exceeds D-1 <= 2^(WIDTH-1), so WIDTH bits hold it.
    logic [WIDTH-1:0] r_p;
    logic [CW-1:0]    r_count;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_ovf;

    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;

    always_comb begin
        w_t       = {r_p, r_a[WIDTH-1]};
        w_diff    = w_t - {1'b0, r_d};
        w_ge      = (w_t >= {1'b0, r_d});
        w_abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
        w_abs_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;
        w_q       = r_sign_q ? -r_a : r_a;
        w_r       = r_sign_r ? -r_p : r_p;
    end

    // NOTE: every register here, datapath included, clears on the async reset so an
    // aborted operation leaves no stale operand behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_d         <= '0;
            r_p         <= '0;
            r_count     <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_ovf       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sign_r <= dividend[WIDTH-1];
                            r_a      <= w_abs_dvd;
                            r_d      <= w_abs_dvs;
                            r_p      <= '0;
                            r_count  <= CW'(WIDTH - 1);
                            r_ovf    <= (dividend == MIN_VAL) && (divisor == '1);
                            busy     <= 1'b1;
                            r_state  <= S_ITER;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ITER: begin
                    r_p <= w_ge ? w_diff[WIDTH-1:0] : w_t[WIDTH-1:0];
                    r_a <= {r_a[WIDTH-2:0], w_ge};
                    if (r_count == '0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_FIX: begin
                    // MIN/-1 needs no special path: |MIN| with a positive sign wraps back to MIN.
                    quotient    <= w_q;
                    remainder   <= w_r;
                    overflow    <= r_ovf;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    r_state     <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_robs_divider.sv
// Directed self-checking bench for robs_divider (WIDTH=8) with hand-computed results.
module tb_robs_divider;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    robs_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; the next edge accepts, and it returns in cycle 1.
    task automatic launch(input logic [7:0] dvd, input logic [7:0] dvs);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Samples cycles 1..30 until done; optionally pulses start with new operands in inj_cyc.
    task automatic watch(input int inj_cyc, input logic [7:0] inj_dvd, input logic [7:0] inj_dvs,
                         output int done_cyc, output int busy_cnt, output int busy_first);
        done_cyc   = 0;
        busy_cnt   = 0;
        busy_first = 0;
        for (int c = 1; c <= 30; c++) begin
            if (busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            if (c == inj_cyc) begin
                start    = 1'b1;
                dividend = inj_dvd;
                divisor  = inj_dvs;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int dcyc, input int bcnt,
                                input int bfirst, input logic [7:0] eq, input logic [7:0] er,
                                input logic edbz, input logic eovf);
        check({tag, "_done_cycle"}, dcyc, lat);
        check({tag, "_busy_cycles"}, bcnt, lat - 1);
        check({tag, "_busy_first"}, bfirst, (lat > 1) ? 1 : 0);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_div_by_zero"}, div_by_zero, edbz);
        check({tag, "_overflow"}, overflow, eovf);
    endtask

    task automatic run_op(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                          input int lat, input logic [7:0] eq, input logic [7:0] er,
                          input logic edbz, input logic eovf);
        int dcyc, bcnt, bfirst;
        launch(dvd, dvs);
        watch(0, 8'h00, 8'h00, dcyc, bcnt, bfirst);
        check_result(tag, lat, dcyc, bcnt, bfirst, eq, er, edbz, eovf);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dcyc, bcnt, bfirst;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 8'h00;
        divisor  = 8'h00;
        #3;
        check("reset_quotient", quotient, 8'h00);
        check("reset_remainder", remainder, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_flags", {div_by_zero, overflow}, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op("pos_pos",   8'd100, 8'd7,  10, 8'd14,  8'd2,  1'b0, 1'b0);
        run_op("neg_pos",   8'h9C,  8'd7,  10, 8'hF2,  8'hFE, 1'b0, 1'b0);
        run_op("pos_neg",   8'd100, 8'hF9, 10, 8'hF2,  8'd2,  1'b0, 1'b0);
        run_op("neg_neg",   8'h9C,  8'hF9, 10, 8'd14,  8'hFE, 1'b0, 1'b0);
        run_op("div_zero",  8'd37,  8'h00, 1,  8'hFF,  8'd37, 1'b1, 1'b0);
        check("hold_done_low", done, 1'b0);
        check("hold_quotient", quotient, 8'hFF);
        check("hold_dbz", div_by_zero, 1'b1);
        run_op("min_neg1",  8'h80,  8'hFF, 10, 8'h80,  8'h00, 1'b0, 1'b1);
        run_op("min_pos1",  8'h80,  8'h01, 10, 8'h80,  8'h00, 1'b0, 1'b0);
        run_op("small_big", 8'd5,   8'd9,  10, 8'h00,  8'd5,  1'b0, 1'b0);

        // Start pulsed mid-operation is ignored; start held in DONE begins a new op.
        launch(8'd100, 8'd7);
        watch(4, 8'd50, 8'd5, dcyc, bcnt, bfirst);
        check_result("busy_ignore", 10, dcyc, bcnt, bfirst, 8'd14, 8'd2, 1'b0, 1'b0);
        launch(8'd50, 8'd5);
        watch(0, 8'h00, 8'h00, dcyc, bcnt, bfirst);
        check_result("back2back", 10, dcyc, bcnt, bfirst, 8'd10, 8'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset in cycle 5 of a new operation.
        launch(8'd100, 8'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async_quotient", quotient, 8'h00);
        check("async_remainder", remainder, 8'h00);
        check("async_busy", busy, 1'b0);
        check("async_done", done, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_reset", 8'd9, 8'd3, 10, 8'd3, 8'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
